// File: rtl/reuleaux_arc_engine.sv
// Programmable clipped-arc drawer: optional full-screen clear, then up to MAX_ARCS
// midpoint-circle arcs taken from a descriptor table, one pixel per cycle.
module reuleaux_arc_engine #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned MAX_ARCS = 4,
   parameter int unsigned XW       = 8,
   parameter int unsigned YW       = 7,
   parameter int unsigned RW       = 8,
   localparam int unsigned IW      = (MAX_ARCS > 1) ? $clog2(MAX_ARCS) : 1,
   localparam int unsigned NW      = $clog2(MAX_ARCS) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic [XW-1:0] cfg_cx,
   input  logic [YW-1:0] cfg_cy,
   input  logic [RW-1:0] cfg_r,
   input  logic [XW-1:0] cfg_xmin,
   input  logic [XW-1:0] cfg_xmax,
   input  logic [YW-1:0] cfg_ymin,
   input  logic [YW-1:0] cfg_ymax,
   input  logic [NW-1:0] num_arcs,
   input  logic          clear_en,
   input  logic [2:0]    colour,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [2:0]    vga_colour,
   output logic          vga_plot
);

   localparam int unsigned MW = (XW > YW) ? ((XW > RW) ? XW : RW) : ((YW > RW) ? YW : RW);
   localparam int unsigned AW = MW + 3;

   typedef logic signed [AW-1:0] sval_t;

   typedef struct packed {
      logic [XW-1:0] cx;
      logic [YW-1:0] cy;
      logic [XW-1:0] xmin;
      logic [XW-1:0] xmax;
      logic [YW-1:0] ymin;
      logic [YW-1:0] ymax;
   } win_t;

   typedef struct packed {
      win_t          w;
      logic [RW-1:0] r;
   } desc_t;

   typedef struct packed {
      logic          plot;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } pix_t;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ARC_INIT, S_ARC_PLOT, S_ARC_STEP, S_DONE
   } state_t;

   localparam sval_t ONE_S = AW'(1);
   localparam sval_t SW_S  = AW'(SCREEN_W);
   localparam sval_t SH_S  = AW'(SCREEN_H);

   state_t        state_q;
   desc_t         tbl_q [MAX_ARCS];
   win_t          cur_q;
   sval_t         ox_q, oy_q, crit_q;
   logic [2:0]    oct_q;
   logic [NW-1:0] k_q, na_q;
   logic [2:0]    arc_col_q;
   logic [XW-1:0] clr_x_q;
   logic [YW-1:0] clr_y_q;
   logic          busy_q, done_q, plot_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [2:0]    col_q;

   sval_t         ox_d, oy_d, crit_d;
   logic          more_d;
   logic [XW-1:0] clr_x_d;
   logic [YW-1:0] clr_y_d;
   logic          clr_eol, clr_last;
   logic [IW-1:0] kidx;
   logic [NW-1:0] k_nxt, na_sat;
   sval_t         r_init;
   win_t          sel_w;
   sval_t         sel_ox, sel_oy;
   logic [2:0]    sel_o;
   pix_t          pix;

   // Octant mirror of (ox,oy) about the centre, clipped to screen and window.
   function automatic pix_t cand(input win_t w, input sval_t ox, input sval_t oy,
                                 input logic [2:0] o);
      sval_t a, b, px, py;
      logic  in_scr, in_win;
      pix_t  p;
      a  = o[0] ? oy : ox;
      b  = o[0] ? ox : oy;
      px = $signed(AW'(w.cx)) + (((o[2] ^ o[1]) != 1'b0) ? -a : a);
      py = $signed(AW'(w.cy)) + (o[2] ? -b : b);
      in_scr = !px[AW-1] && !py[AW-1] && (px < SW_S) && (py < SH_S);
      in_win = (px >= $signed(AW'(w.xmin))) && (px <= $signed(AW'(w.xmax))) &&
               (py >= $signed(AW'(w.ymin))) && (py <= $signed(AW'(w.ymax)));
      p.plot = in_scr && in_win;
      p.x    = px[XW-1:0];
      p.y    = py[YW-1:0];
      return p;
   endfunction

   assign kidx     = k_q[IW-1:0];
   assign k_nxt    = k_q + NW'(1);
   assign na_sat   = (num_arcs > NW'(MAX_ARCS)) ? NW'(MAX_ARCS) : num_arcs;
   assign r_init   = AW'(tbl_q[kidx].r);
   assign clr_eol  = (clr_x_q == XW'(SCREEN_W - 1));
   assign clr_last = clr_eol && (clr_y_q == YW'(SCREEN_H - 1));
   assign clr_x_d  = clr_eol ? '0 : clr_x_q + XW'(1);
   assign clr_y_d  = clr_eol ? clr_y_q + YW'(1) : clr_y_q;

   // Midpoint-circle step; oy/ox updated before the criterion uses them.
   always_comb begin
      oy_d   = oy_q + ONE_S;
      ox_d   = ox_q;
      crit_d = crit_q;
      if (crit_q[AW-1] || (crit_q == '0)) begin
         crit_d = crit_q + (oy_d <<< 1) + ONE_S;
      end else begin
         ox_d   = ox_q - ONE_S;
         crit_d = crit_q + ((oy_d - ox_d) <<< 1) + ONE_S;
      end
      more_d = (oy_d <= ox_d);
   end

   // Pixel registered on the edge entering each plot cycle.
   always_comb begin
      sel_w  = cur_q;
      sel_ox = ox_q;
      sel_oy = oy_q;
      sel_o  = oct_q + 3'd1;
      case (state_q)
         S_ARC_INIT: begin
            sel_w  = tbl_q[kidx].w;
            sel_ox = r_init;
            sel_oy = '0;
            sel_o  = 3'd0;
         end
         S_ARC_STEP: begin
            sel_ox = ox_d;
            sel_oy = oy_d;
            sel_o  = 3'd0;
         end
         default: ;
      endcase
      pix = cand(sel_w, sel_ox, sel_oy, sel_o);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < int'(MAX_ARCS); i++) tbl_q[i] <= '0;
         cur_q     <= '0;
         ox_q      <= '0;
         oy_q      <= '0;
         crit_q    <= '0;
         oct_q     <= '0;
         k_q       <= '0;
         na_q      <= '0;
         arc_col_q <= '0;
         clr_x_q   <= '0;
         clr_y_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         plot_q    <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         col_q     <= '0;
      end else begin
         // Descriptor writes only land while idle; unmatched indices drop out.
         if (cfg_we && !busy_q) begin
            for (int i = 0; i < int'(MAX_ARCS); i++) begin
               if (cfg_idx == IW'(i)) begin
                  tbl_q[i] <= '{w: '{cx: cfg_cx, cy: cfg_cy, xmin: cfg_xmin, xmax: cfg_xmax,
                                     ymin: cfg_ymin, ymax: cfg_ymax},
                                r: cfg_r};
               end
            end
         end
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               plot_q <= 1'b0;
               if (start) begin
                  busy_q    <= 1'b1;
                  arc_col_q <= colour;
                  na_q      <= na_sat;
                  k_q       <= '0;
                  if (clear_en) begin
                     state_q <= S_CLEAR;
                     clr_x_q <= '0;
                     clr_y_q <= '0;
                     x_q     <= '0;
                     y_q     <= '0;
                     col_q   <= '0;
                     plot_q  <= 1'b1;
                  end else if (na_sat != '0) begin
                     state_q <= S_ARC_INIT;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               if (clr_last) begin
                  plot_q <= 1'b0;
                  if (na_q != '0) begin
                     state_q <= S_ARC_INIT;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  clr_x_q <= clr_x_d;
                  clr_y_q <= clr_y_d;
                  x_q     <= clr_x_d;
                  y_q     <= clr_y_d;
                  plot_q  <= 1'b1;
               end
            end
            S_ARC_INIT: begin
               cur_q   <= tbl_q[kidx].w;
               ox_q    <= r_init;
               oy_q    <= '0;
               crit_q  <= ONE_S - r_init;
               oct_q   <= '0;
               col_q   <= arc_col_q;
               x_q     <= pix.x;
               y_q     <= pix.y;
               plot_q  <= pix.plot;
               state_q <= S_ARC_PLOT;
            end
            S_ARC_PLOT: begin
               if (oct_q == 3'd7) begin
                  plot_q  <= 1'b0;
                  state_q <= S_ARC_STEP;
               end else begin
                  oct_q  <= oct_q + 3'd1;
                  x_q    <= pix.x;
                  y_q    <= pix.y;
                  plot_q <= pix.plot;
               end
            end
            S_ARC_STEP: begin
               ox_q   <= ox_d;
               oy_q   <= oy_d;
               crit_q <= crit_d;
               if (more_d) begin
                  oct_q   <= '0;
                  x_q     <= pix.x;
                  y_q     <= pix.y;
                  plot_q  <= pix.plot;
                  state_q <= S_ARC_PLOT;
               end else begin
                  k_q <= k_nxt;
                  if (k_nxt < na_q) begin
                     state_q <= S_ARC_INIT;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               plot_q <= 1'b0;
               if (!start) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign vga_x      = x_q;
   assign vga_y      = y_q;
   assign vga_colour = col_q;
   assign vga_plot   = plot_q;

endmodule

// File: tb/tb_reuleaux_arc_engine.sv
// Directed bench for reuleaux_arc_engine: clear raster, reset, single arcs,
// clipping, table sequencing and start/done handshake.
module tb_reuleaux_arc_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [7:0] cfg_cx, cfg_xmin, cfg_xmax;
   logic [6:0] cfg_cy, cfg_ymin, cfg_ymax;
   logic [7:0] cfg_r;
   logic [2:0] num_arcs;
   logic       clear_en;
   logic [2:0] colour;
   logic       start;
   logic       busy, done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int n_tests = 0;
   int n_fail  = 0;
   int px_q[$], py_q[$], pc_q[$], pcyc_q[$];
   int done_cyc, wrap_cnt, busy_drop;

   always #5 clk = ~clk;

   reuleaux_arc_engine dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r),
      .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax), .cfg_ymin(cfg_ymin), .cfg_ymax(cfg_ymax),
      .num_arcs(num_arcs), .clear_en(clear_en), .colour(colour), .start(start),
      .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_desc(input int idx, input int cx, input int cy, input int r,
                           input int xmin, input int xmax, input int ymin, input int ymax);
      cfg_idx  = 2'(idx);
      cfg_cx   = 8'(cx);
      cfg_cy   = 7'(cy);
      cfg_r    = 8'(r);
      cfg_xmin = 8'(xmin);
      cfg_xmax = 8'(xmax);
      cfg_ymin = 7'(ymin);
      cfg_ymax = 7'(ymax);
      cfg_we   = 1'b1;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // Raise start, log every plotted pixel until done, then check the handshake.
   task automatic run(input string tag, input int max_cyc, input bit poke);
      logic [7:0] r_save;
      px_q.delete(); py_q.delete(); pc_q.delete(); pcyc_q.delete();
      done_cyc  = -1;
      wrap_cnt  = 0;
      busy_drop = 0;
      r_save    = cfg_r;
      start     = 1'b1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (c == 1) begin
            cfg_we = 1'b0;
            colour = 3'd2;
         end
         if (poke && c == 3) begin
            cfg_r  = 8'd7;
            cfg_we = 1'b1;
         end
         if (poke && c == 4) begin
            cfg_r  = r_save;
            cfg_we = 1'b0;
         end
         if (!busy) busy_drop++;
         if (vga_plot) begin
            px_q.push_back(int'(vga_x));
            py_q.push_back(int'(vga_y));
            pc_q.push_back(int'(vga_colour));
            pcyc_q.push_back(c);
            if (vga_x >= 8'd160 || vga_y >= 7'd120) wrap_cnt++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      check({tag, " busy_during"}, busy_drop, 0);
      @(negedge clk);
      check({tag, " done_hold"}, {29'd0, done, busy, vga_plot}, 32'b110);
      start = 1'b0;
      @(negedge clk);
      check({tag, " done_clear"}, {30'd0, done, busy}, 32'b00);
   endtask

   initial begin
      int bad;
      int ex1[16] = '{6, 5, 4, 5, 4, 5, 6, 5, 6, 6, 4, 4, 4, 4, 6, 6};
      int ey1[16] = '{5, 6, 5, 6, 5, 4, 5, 4, 6, 6, 6, 6, 4, 4, 4, 4};
      int exw[6]  = '{6, 5, 5, 6, 6, 6};
      int eyw[6]  = '{5, 6, 6, 5, 6, 6};

      rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_cx = '0; cfg_cy = '0; cfg_r = '0;
      cfg_xmin = '0; cfg_xmax = '0; cfg_ymin = '0; cfg_ymax = '0;
      num_arcs = '0; clear_en = 1'b0; colour = 3'd5; start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst plot", vga_plot, 0);
      check("rst xy", {vga_x, 1'b0, vga_y}, 0);
      check("rst colour", vga_colour, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full clear, no arcs.
      clear_en = 1'b1; num_arcs = 3'd0; colour = 3'd5;
      run("clear", 19400, 1'b0);
      check("clear done_cyc", done_cyc, 19201);
      check("clear plots", px_q.size(), 19200);
      bad = 0;
      for (int i = 0; i < px_q.size(); i++)
         if (px_q[i] != i % 160 || py_q[i] != i / 160 || pc_q[i] != 0) bad++;
      check("clear raster", bad, 0);
      check("clear last", (px_q.size() == 19200) ? px_q[19199] * 256 + py_q[19199] : -1,
            159 * 256 + 119);

      // Reset in the middle of a clear.
      start = 1'b1;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst plot_busy_done", {29'd0, vga_plot, busy, done}, 0);
      check("midrst xy_col", {vga_x, vga_y, vga_colour}, 0);
      rst_n = 1'b1; start = 1'b0; clear_en = 1'b0;
      @(negedge clk);

      // Zeroed table: r=0 at (0,0), window 0..0.
      num_arcs = 3'd1; colour = 3'd5;
      run("zero", 100, 1'b0);
      check("zero done_cyc", done_cyc, 11);
      check("zero plots", px_q.size(), 8);
      bad = 0;
      foreach (px_q[i]) if (px_q[i] != 0 || py_q[i] != 0) bad++;
      check("zero pos", bad, 0);

      // r=0 at (10,10), with a write attempted while busy.
      set_desc(0, 10, 10, 0, 0, 159, 0, 119);
      colour = 3'd5;
      run("r0 poke", 100, 1'b1);
      check("r0 done_cyc", done_cyc, 11);
      check("r0 plots", px_q.size(), 8);
      bad = 0;
      foreach (px_q[i]) if (px_q[i] != 10 || py_q[i] != 10 || pc_q[i] != 5) bad++;
      check("r0 pos", bad, 0);
      colour = 3'd5;
      run("r0 again", 100, 1'b0);
      check("r0 again plots", px_q.size(), 8);

      // r=1 at (5,5), written in the same cycle start is accepted.
      cfg_idx = 2'd0; cfg_cx = 8'd5; cfg_cy = 7'd5; cfg_r = 8'd1;
      cfg_xmin = 8'd0; cfg_xmax = 8'd159; cfg_ymin = 7'd0; cfg_ymax = 7'd119;
      cfg_we = 1'b1; colour = 3'd5;
      run("r1", 100, 1'b0);
      check("r1 done_cyc", done_cyc, 20);
      check("r1 plots", px_q.size(), 16);
      bad = 0;
      for (int i = 0; i < 16 && i < px_q.size(); i++)
         if (px_q[i] != ex1[i] || py_q[i] != ey1[i] || pc_q[i] != 5) bad++;
      check("r1 seq", bad, 0);

      // Same arc clipped to x 5..6, y 5..6.
      set_desc(0, 5, 5, 1, 5, 6, 5, 6);
      colour = 3'd5;
      run("win", 100, 1'b0);
      check("win done_cyc", done_cyc, 20);
      check("win plots", px_q.size(), 6);
      bad = 0;
      for (int i = 0; i < 6 && i < px_q.size(); i++)
         if (px_q[i] != exw[i] || py_q[i] != eyw[i]) bad++;
      check("win seq", bad, 0);

      // Empty window: full-length arc, nothing plotted.
      set_desc(0, 5, 5, 1, 9, 3, 0, 119);
      run("empty", 100, 1'b0);
      check("empty done_cyc", done_cyc, 20);
      check("empty plots", px_q.size(), 0);

      // Arc near the origin: negative candidates must not plot.
      set_desc(0, 2, 2, 5, 0, 159, 0, 119);
      run("edge", 200, 1'b0);
      check("edge done_cyc", done_cyc, 38);
      check("edge plots", px_q.size(), 14);
      check("edge wrap", wrap_cnt, 0);

      // Three-arc Reuleaux triangle, back to back.
      set_desc(0, 40, 40, 5, 0, 159, 0, 119);
      set_desc(1, 45, 40, 5, 0, 159, 0, 119);
      set_desc(2, 42, 44, 5, 0, 159, 0, 119);
      set_desc(3, 100, 100, 0, 0, 159, 0, 119);
      num_arcs = 3'd3;
      run("tri", 400, 1'b0);
      check("tri done_cyc", done_cyc, 112);
      check("tri plots", px_q.size(), 96);
      check("tri arc1 cyc", (px_q.size() > 64) ? pcyc_q[32] : -1, 39);
      check("tri arc2 cyc", (px_q.size() > 64) ? pcyc_q[64] : -1, 76);
      check("tri arc1 pix", (px_q.size() > 64) ? px_q[32] * 256 + py_q[32] : -1, 50 * 256 + 40);
      check("tri arc2 pix", (px_q.size() > 64) ? px_q[64] * 256 + py_q[64] : -1, 47 * 256 + 44);

      // num_arcs above the table depth saturates to four arcs.
      num_arcs = 3'd7;
      run("sat", 400, 1'b0);
      check("sat done_cyc", done_cyc, 122);
      check("sat plots", px_q.size(), 104);

      // Nothing to do: straight to done.
      num_arcs = 3'd0;
      run("none", 20, 1'b0);
      check("none done_cyc", done_cyc, 1);
      check("none plots", px_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
